mult_booth: RTL
===============

Name: mult_booth

Overview:
- Sequential signed multiplier for the CPU's MULT instruction; the multiply counterpart of the iterative divider.
- Computes the full 2*WIDTH-bit two's-complement product of A and B using radix-2 Booth recoding, one iteration per clock.
- Writes the result to HI (upper half) and LO (lower half).
- Signals completion to the control unit with a one-cycle MultStop pulse.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits; the iteration count equals WIDTH.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
A  input  WIDTH  multiplicand, signed; sampled only on the start edge.
B  input  WIDTH  multiplier, signed; sampled only on the start edge.
CtrlMult  input  1  start request from control; sampled each edge.
MultBusy  output  1  high while an operation is in progress (RUN state).
MultStop  output  1  one-cycle completion pulse; HI/LO are valid while it is high.
HI  output  WIDTH  product bits [2*WIDTH-1:WIDTH].
LO  output  WIDTH  product bits [WIDTH-1:0].

Behaviour:
- Interface: reset is synchronous and active-high; the clock is clk. Reset has priority over everything, including CtrlMult.
- Reset values: HI=0, LO=0, MultStop=0, MultBusy=0, state=IDLE, internal registers cleared.
- Internal registers:
  - M: WIDTH+1 bits, A sign-extended.
  - ACC: WIDTH+1 bits, signed accumulator.
  - Q: WIDTH bits, multiplier/low product.
  - Q_1: 1 bit, Booth guard.
  - CNT: counts remaining iterations.
- States: IDLE, RUN, DONE.
- IDLE or DONE, with CtrlMult=1 at an edge:
  - Load M=sext(A), ACC=0, Q=B, Q_1=0, CNT=WIDTH.
  - Go to RUN; MultBusy=1.
  - HI/LO keep their previous values.
- RUN, each edge, on {Q[0],Q_1}:
  - 01: ACC=ACC+M.
  - 10: ACC=ACC-M.
  - 00/11: no change.
  - Then shift {ACC,Q,Q_1} right by 1 arithmetically (ACC MSB replicated).
  - CNT decrements. The edge that completes the last iteration (CNT 1->0) moves to DONE.
- Entry into DONE (same edge as the last iteration):
  - HI=ACC[WIDTH-1:0] of the shifted value; LO=Q of the shifted value.
  - MultStop=1, MultBusy=0.
- DONE lasts exactly one cycle. At the next edge MultStop=0 and the state goes to IDLE, unless CtrlMult=1, which starts a new operation (back-to-back allowed).
- Latency: if CtrlMult is sampled at edge N, HI/LO are updated and MultStop rises at edge N+WIDTH, and MultStop falls at edge N+WIDTH+1. For WIDTH=32 this is a 32-cycle op.
- CtrlMult during RUN is ignored. The operation is not restarted and the latched operands are unaffected.
- A/B changes after the start edge have no effect.
- Arithmetic: the WIDTH+1-bit accumulator prevents overflow for M = -2^(WIDTH-1). The result is exact for all operand pairs, with no overflow or exception flag.
- Reset mid-RUN: abort immediately; HI=LO=0; no MultStop pulse. A new start is accepted on the first edge after reset deasserts.
- Simultaneous reset and CtrlMult: reset wins and no operation starts.
- MultStop is never asserted without a preceding accepted start. It is never high for more than one consecutive cycle unless back-to-back operations complete on consecutive opportunities; that cannot happen because the minimum spacing is WIDTH cycles.

Test Plan:
1. Reset then A=7, B=3, CtrlMult pulse -> MultBusy high for 32 cycles; MultStop high exactly one cycle, 32 edges after start; HI=0x00000000, LO=0x00000015.
2. A=0xFFFFFFF9 (-7), B=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then A=B=0xFFFFFFFF (-1*-1) -> HI=0, LO=1.
3. Corner operands:
   - A=B=0x80000000 -> HI=0x40000000, LO=0x00000000.
   - A=B=0x7FFFFFFF -> HI=0x3FFFFFFF, LO=0x00000001.
   - A=0x80000000, B=1 -> HI=0xFFFFFFFF, LO=0x80000000.
4. Start 5*6, assert reset at iteration 10 -> no MultStop ever; HI=LO=0; MultBusy=0. Next start 2*2 -> LO=4 after 32 cycles.
5. Start 9*9. At cycle 5 change A/B to 100/100 and pulse CtrlMult -> result LO=81, completing at the original 32-cycle mark; no second operation starts.
6. Hold CtrlMult=1 with A=3, B=4 into the DONE cycle of a prior 2*2 -> LO=4 with a one-cycle MultStop, then immediate restart; 32 edges later LO=12 with a second one-cycle MultStop.

Source files
------------

// File: rtl/mult_booth.sv
// Iterative radix-2 Booth signed multiplier: one Booth step per clock, WIDTH steps per operation.
// The full 2*WIDTH-bit product lands in HI/LO together with a one-cycle MultStop pulse.
module mult_booth #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CtrlMult,
  output logic             MultBusy,
  output logic             MultStop,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH:0]   r_m;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic             r_q1;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_acc_n;
  logic [WIDTH-1:0] w_q_n;
  logic             w_q1_n;

  // Booth add/sub on {Q[0],Q_1}, then arithmetic right shift of {ACC,Q,Q_1}.
  // The extra accumulator bit keeps M = -2^(WIDTH-1) from overflowing.
  always_comb begin
    w_sum = r_acc;
    case ({r_q[0], r_q1})
      2'b01:   w_sum = r_acc + r_m;
      2'b10:   w_sum = r_acc - r_m;
      default: w_sum = r_acc;
    endcase
    w_acc_n = {w_sum[WIDTH], w_sum[WIDTH:1]};
    w_q_n   = {w_sum[0], r_q[WIDTH-1:1]};
    w_q1_n  = r_q[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_m      <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_q1     <= 1'b0;
      r_cnt    <= '0;
      HI       <= '0;
      LO       <= '0;
      MultBusy <= 1'b0;
      MultStop <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          MultStop <= 1'b0;
          if (CtrlMult) begin
            r_m      <= {A[WIDTH-1], A};
            r_acc    <= '0;
            r_q      <= B;
            r_q1     <= 1'b0;
            r_cnt    <= CW'(WIDTH);
            r_state  <= RUN;
            MultBusy <= 1'b1;
          end else begin
            r_state  <= IDLE;
            MultBusy <= 1'b0;
          end
        end
        RUN: begin
          r_acc <= w_acc_n;
          r_q   <= w_q_n;
          r_q1  <= w_q1_n;
          r_cnt <= r_cnt - CW'(1);
          // Last step: publish the shifted result on the same edge.
          if (r_cnt == CW'(1)) begin
            HI       <= w_acc_n[WIDTH-1:0];
            LO       <= w_q_n;
            MultStop <= 1'b1;
            MultBusy <= 1'b0;
            r_state  <= DONE;
          end
        end
        default: begin
          r_state  <= IDLE;
          MultBusy <= 1'b0;
          MultStop <= 1'b0;
        end
      endcase
    end
  end
endmodule
